// File: rtl/enc_seq_prio.sv
// Sequential priority encoder: captures a multi-hot request vector and emits one
// binary index per valid/ready handshake, lowest index first. Optional macro: ENC_SEQ_MERGE_EN.
module enc_seq_prio #(
  parameter  int N  = 4,
  localparam int W  = $clog2(N),
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          e,
  input  logic          load,
  input  logic [N-1:0]  a,
  input  logic          rdy,
  output logic [W-1:0]  y,
  output logic          v,
  output logic          busy,
  output logic [CW-1:0] cnt,
  output logic          done
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   pend_q, pend_d;
  logic           done_q, done_d;

  logic [N-1:0]   lowest_oh;
  logic [N-1:0]   pop_oh;
  logic [W-1:0]   idx_c;
  logic [CW-1:0]  cnt_c;

  // Isolates the lowest set bit of pend; this is the bit a transfer removes.
  assign lowest_oh = pend_q & (~pend_q + N'(1));
  assign pop_oh    = (state_q == BUSY && rdy) ? lowest_oh : '0;

  always_comb begin
    idx_c = '0;
    cnt_c = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pend_q[i]) idx_c = W'(i);
    end
    for (int i = 0; i < N; i++) begin
      cnt_c = cnt_c + CW'(pend_q[i]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load && e && a != '0) begin
          pend_d  = a;
          state_d = BUSY;
        end
      end
      BUSY: begin
        pend_d = pend_q & ~pop_oh;
`ifdef ENC_SEQ_MERGE_EN
        if (load && e) pend_d = pend_d | a;
`endif
        if (pend_d == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    v    = (state_q == BUSY);
    busy = (state_q == BUSY);
    y    = v ? idx_c : '0;
    cnt  = cnt_c;
    done = done_q;
  end

endmodule

// File: tb/tb_enc_seq_prio.sv
// Self-checking bench for enc_seq_prio: directed vector table, hand-written reset
// sequences, and randomized traffic against a queue-based reference model.
module tb_enc_seq_prio;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       e = 1'b0, load = 1'b0, rdy = 1'b0;
  logic [3:0] a = '0;
  logic [1:0] y;
  logic       v, busy, done;
  logic [2:0] cnt;

  int n_checks = 0;
  int n_pass   = 0;

  enc_seq_prio #(.N(N)) dut (
    .clk(clk), .rst(rst), .e(e), .load(load), .a(a), .rdy(rdy),
    .y(y), .v(v), .busy(busy), .cnt(cnt), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       e, load;
    logic [3:0] a;
    logic       rdy;
    int         ey, ev, eb, ec, ed;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_outs(input string tag, input int ey, input int ev, input int eb,
                            input int ec, input int ed);
    check({tag, ".y"},    int'(y),    ey);
    check({tag, ".v"},    int'(v),    ev);
    check({tag, ".busy"}, int'(busy), eb);
    check({tag, ".cnt"},  int'(cnt),  ec);
    check({tag, ".done"}, int'(done), ed);
  endtask

  function automatic void add(input logic ie, input logic il, input logic [3:0] ia,
                              input logic ir, input int ey, input int ev, input int eb,
                              input int ec, input int ed);
    vec_t t;
    t.e = ie; t.load = il; t.a = ia; t.rdy = ir;
    t.ey = ey; t.ev = ev; t.eb = eb; t.ec = ec; t.ed = ed;
    tbl.push_back(t);
  endfunction

  // Reference model: pending requests as a sorted queue of indices.
  int  mq[$];
  bit  mdone;

  function automatic void model_step(input logic me, input logic ml, input logic [3:0] ma,
                                     input logic mr);
    bit popped = 0;
    mdone = 0;
    if (mq.size() == 0) begin
      if (ml && me && ma != 0)
        for (int i = 0; i < N; i++) if (ma[i]) mq.push_back(i);
    end else begin
      if (mr) begin
        void'(mq.pop_front());
        popped = 1;
      end
`ifdef ENC_SEQ_MERGE_EN
      if (ml && me) begin
        for (int i = 0; i < N; i++) begin
          bit present = 0;
          foreach (mq[k]) if (mq[k] == i) present = 1;
          if (ma[i] && !present) mq.push_back(i);
        end
        mq.sort();
      end
`endif
      if (popped && mq.size() == 0) mdone = 1;
    end
  endfunction

  initial begin
    // Power-on reset
    repeat (2) @(negedge clk);
    check_outs("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Directed table: inputs driven on a negedge, outputs there reflect prior rows.
    add(1,1,4'b1010,1, 0,0,0,0,0);
    add(0,0,4'b0000,1, 1,1,1,2,0);
    add(0,0,4'b0000,1, 3,1,1,1,0);
    add(0,0,4'b0000,1, 0,0,0,0,1);
    add(0,0,4'b0000,1, 0,0,0,0,0);
    add(1,1,4'b0110,0, 0,0,0,0,0);
    add(0,0,4'b0000,0, 1,1,1,2,0);
    add(0,0,4'b0000,0, 1,1,1,2,0);
    add(0,0,4'b0000,0, 1,1,1,2,0);
    add(0,0,4'b0000,1, 1,1,1,2,0);
    add(0,0,4'b0000,1, 2,1,1,1,0);
    add(0,0,4'b0000,1, 0,0,0,0,1);
    add(0,0,4'b0000,1, 0,0,0,0,0);
    add(1,1,4'b0000,1, 0,0,0,0,0);
    add(0,0,4'b0000,1, 0,0,0,0,0);
    add(0,1,4'b1111,1, 0,0,0,0,0);
    add(0,0,4'b0000,1, 0,0,0,0,0);
    add(1,1,4'b1111,1, 0,0,0,0,0);
    add(0,0,4'b0000,1, 0,1,1,4,0);
    add(0,0,4'b0000,1, 1,1,1,3,0);
    add(0,0,4'b0000,1, 2,1,1,2,0);
    add(0,0,4'b0000,1, 3,1,1,1,0);
    add(0,0,4'b0000,1, 0,0,0,0,1);
    add(0,0,4'b0000,1, 0,0,0,0,0);
    add(1,1,4'b0100,0, 0,0,0,0,0);
    add(1,1,4'b0001,0, 2,1,1,1,0);
`ifdef ENC_SEQ_MERGE_EN
    add(0,0,4'b0000,1, 0,1,1,2,0);
    add(0,0,4'b0000,1, 2,1,1,1,0);
    add(0,0,4'b0000,1, 0,0,0,0,1);
`else
    add(0,0,4'b0000,1, 2,1,1,1,0);
    add(0,0,4'b0000,1, 0,0,0,0,1);
    add(0,0,4'b0000,1, 0,0,0,0,0);
`endif
    add(0,0,4'b0000,1, 0,0,0,0,0);

    foreach (tbl[i]) begin
      @(negedge clk);
      e = tbl[i].e; load = tbl[i].load; a = tbl[i].a; rdy = tbl[i].rdy;
      check_outs($sformatf("vec%0d", i), tbl[i].ey, tbl[i].ev, tbl[i].eb, tbl[i].ec, tbl[i].ed);
    end

    // Mid-operation async reset after two transfers, checked before the next edge.
    @(negedge clk);
    e = 1; load = 1; a = 4'b1111; rdy = 1;
    @(negedge clk);
    load = 0; a = 0;
    check_outs("midop.t0", 0, 1, 1, 4, 0);
    @(negedge clk);
    check_outs("midop.t1", 1, 1, 1, 3, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_outs("async_rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    check_outs("rst_hold", 0, 0, 0, 0, 0);
    @(negedge clk);
    check_outs("rst_nodone", 0, 0, 0, 0, 0);
    load = 1; a = 4'b1000;
    @(negedge clk);
    load = 0; a = 0;
    check_outs("after_rst.y3", 3, 1, 1, 1, 0);
    @(negedge clk);
    check_outs("after_rst.done", 0, 0, 0, 0, 1);
    @(negedge clk);
    check_outs("after_rst.idle", 0, 0, 0, 0, 0);

    // Randomized traffic against the reference model; DUT and model are both idle here.
    mq.delete();
    mdone = 0;
    for (int c = 0; c < 400; c++) begin
      logic       re, rl, rr;
      logic [3:0] ra;
      @(negedge clk);
      check("rnd.v",    int'(v),    (mq.size() > 0) ? 1 : 0);
      check("rnd.busy", int'(busy), (mq.size() > 0) ? 1 : 0);
      check("rnd.y",    int'(y),    (mq.size() > 0) ? mq[0] : 0);
      check("rnd.cnt",  int'(cnt),  mq.size());
      check("rnd.done", int'(done), int'(mdone));
      re = ($urandom_range(0, 3) != 0);
      rl = ($urandom_range(0, 2) == 0);
      ra = 4'($urandom_range(0, 15));
      rr = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 31) == 0) begin
        rst = 1'b1;
        #1 rst = 1'b0;
        mq.delete();
        mdone = 0;
      end
      e = re; load = rl; a = ra; rdy = rr;
      model_step(re, rl, ra, rr);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
